// File: rtl/nn_pkg.sv
// Shared definitions for the threshold-network frame driver: state encoding,
// frame word width and the default network geometry.
package nn_pkg;

  localparam int unsigned NN_WORD_W         = 32;
  localparam int unsigned NN_N1_DEFAULT     = 8;
  localparam int unsigned NN_SETTLE_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_TH2 = 3'd1,
    GET_S   = 3'd2,
    SETTLE  = 3'd3,
    RESULT  = 3'd4
  } nn_state_t;

endpackage

// File: rtl/nn_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones once reached.
module nn_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/nn_frame_driver.sv
// Stream front/back-end for the combinational threshold network: loads
// thresholds and synapses, waits a settle time, returns the tagged axon.
module nn_frame_driver
  import nn_pkg::*;
#(
  parameter int unsigned N1            = NN_N1_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = NN_SETTLE_DEFAULT,
  parameter int unsigned TAG_W         = 8,
  parameter int unsigned FIRE_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NN_WORD_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sticky_th,
  output logic [N1-1:0]        nn_s,
  output logic [NN_WORD_W-1:0] nn_th1,
  output logic [NN_WORD_W-1:0] nn_th2,
  input  logic                 nn_ax,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_ax,
  output logic [TAG_W-1:0]     out_tag,
  output logic [FIRE_W-1:0]    fire_cnt,
  output logic                 busy
);

  localparam int unsigned     SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

  nn_state_t       state;
  logic [SC_W-1:0] settle_cnt;
  logic            accept;
  logic            settle_done;
  logic            fire_inc;
  logic            unused_in_bits;

  assign in_ready    = (state == IDLE) || (state == GET_TH2) || (state == GET_S);
  assign accept      = in_valid && in_ready;
  assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
  assign fire_inc    = settle_done && nn_ax;
  assign busy        = (state != IDLE);

  // Synapse words only use the low N1 bits; the rest is deliberately dropped.
  assign unused_in_bits = ^in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      nn_s       <= '0;
      nn_th1     <= '0;
      nn_th2     <= '0;
      out_valid  <= 1'b0;
      out_ax     <= 1'b0;
      out_tag    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (sticky_th) begin
              nn_s  <= in_data[N1-1:0];
              state <= SETTLE;
            end else begin
              nn_th1 <= in_data;
              state  <= GET_TH2;
            end
          end
        end
        GET_TH2: begin
          if (accept) begin
            nn_th2 <= in_data;
            state  <= GET_S;
          end
        end
        GET_S: begin
          if (accept) begin
            nn_s  <= in_data[N1-1:0];
            state <= SETTLE;
          end
        end
        SETTLE: begin
          // Counter is left at zero on exit so the next frame starts clean.
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            out_ax     <= nn_ax;
            out_valid  <= 1'b1;
            state      <= RESULT;
          end else begin
            settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_tag   <= out_tag + TAG_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  nn_sat_counter #(
    .W (FIRE_W)
  ) u_fire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fire_inc),
    .count (fire_cnt)
  );

endmodule

// File: tb/tb_nn_frame_driver.sv
// Self-checking bench for nn_frame_driver with a behavioural window-neuron
// network and a frame-level reference model.
module tb_nn_frame_driver;
  import nn_pkg::*;

  localparam int unsigned N1     = 8;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned TAG_W  = 8;
  localparam int unsigned FIRE_W = 4;
  localparam int unsigned TAG_MOD  = 2 ** TAG_W;
  localparam int unsigned FIRE_MAX = (2 ** FIRE_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              sticky_th;
  logic [N1-1:0]     nn_s;
  logic [31:0]       nn_th1;
  logic [31:0]       nn_th2;
  logic              nn_ax;
  logic              out_valid;
  logic              out_ready;
  logic              out_ax;
  logic [TAG_W-1:0]  out_tag;
  logic [FIRE_W-1:0] fire_cnt;
  logic              busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state: what the driver should be holding / reporting.
  int unsigned m_th1, m_th2, m_s, m_results, m_fire;

  always #5 clk = ~clk;

  nn_frame_driver #(
    .N1            (N1),
    .SETTLE_CYCLES (SETTLE),
    .TAG_W         (TAG_W),
    .FIRE_W        (FIRE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sticky_th (sticky_th),
    .nn_s      (nn_s),
    .nn_th1    (nn_th1),
    .nn_th2    (nn_th2),
    .nn_ax     (nn_ax),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ax    (out_ax),
    .out_tag   (out_tag),
    .fire_cnt  (fire_cnt),
    .busy      (busy)
  );

  // Synapse i carries weight 2^i; the window neuron fires for th1 <= sum < th2.
  function automatic logic window(input int unsigned s, input int unsigned th1,
                                  input int unsigned th2);
    longint unsigned sum = 0;
    for (int i = 0; i < int'(N1); i++)
      if (((s >> i) & 1) != 0) sum += longint'(1) << i;
    return (sum >= th1) && (sum < th2);
  endfunction

  always_comb nn_ax = window(32'(nn_s), nn_th1, nn_th2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zeroed();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ax", out_ax, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_fire_cnt", fire_cnt, 0);
    check("rst_nn_s", nn_s, 0);
    check("rst_nn_th1", nn_th1, 0);
    check("rst_nn_th2", nn_th2, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_zeroed();
    in_valid = 1'b0; sticky_th = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    m_th1 = 0; m_th2 = 0; m_s = 0; m_results = 0; m_fire = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic st);
    int unsigned n = 0;
    in_data = d; sticky_th = st; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; sticky_th = 1'b0;
  endtask

  task automatic gap_wait(input int unsigned gap);
    repeat (gap) begin
      @(posedge clk); #1;
      check("gap_busy", busy, 1);
      check("gap_in_ready", in_ready, 1);
    end
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic get_result(input int unsigned hold, input logic push_next,
                            input logic [31:0] next_word);
    int unsigned n;
    logic exp_ax;
    exp_ax = window(m_s, m_th1, m_th2);
    wait_valid(n);
    check("latency", n, SETTLE);
    check("out_valid", out_valid, 1);
    if (exp_ax) m_fire++;
    check("out_ax", out_ax, exp_ax);
    check("out_tag", out_tag, m_results % TAG_MOD);
    check("fire_cnt", fire_cnt, (m_fire > FIRE_MAX) ? FIRE_MAX : m_fire);
    if (push_next) begin in_data = next_word; sticky_th = 1'b1; in_valid = 1'b1; end
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_ax", out_ax, exp_ax);
      check("hold_tag", out_tag, m_results % TAG_MOD);
      check("hold_nn_s", nn_s, m_s);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_results++;
    check("released", out_valid, 0);
    check("tag_advance", out_tag, m_results % TAG_MOD);
  endtask

  task automatic do_frame(input logic st, input logic [31:0] th1, input logic [31:0] th2,
                          input logic [31:0] s, input int unsigned gap, input int unsigned hold);
    if (!st) begin
      send_word(th1, 1'b0); m_th1 = th1;
      gap_wait(gap);
      send_word(th2, 1'($urandom_range(0, 1))); m_th2 = th2;
      gap_wait(gap);
      send_word(s, 1'($urandom_range(0, 1)));
    end else begin
      send_word(s, 1'b1);
    end
    m_s = s % (2 ** N1);
    get_result(hold, 1'b0, 32'd0);
    check("held_th1", nn_th1, m_th1);
    check("held_th2", nn_th2, m_th2);
    check("held_s", nn_s, m_s);
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; sticky_th = 1'b0; out_ready = 1'b0;
    m_th1 = 0; m_th2 = 0; m_s = 0; m_results = 0; m_fire = 0;
    #3;
    check_zeroed();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);

    // Full frame, then sticky frame reusing thresholds.
    do_frame(1'b0, 32'd16, 32'd64, 32'h20, 0, 0);
    do_frame(1'b1, 32'd0, 32'd0, 32'h80, 0, 0);

    // Back-pressure with a word waiting; it must be taken one cycle after release.
    send_word(32'h30, 1'b1);
    m_s = 32'h30;
    get_result(10, 1'b1, 32'hFFFF_FF05);
    check("bp_idle", busy, 0);
    check("bp_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; sticky_th = 1'b0;
    check("bp_accepted", busy, 1);
    m_s = 32'h05;
    get_result(0, 1'b0, 32'd0);

    // out_ready with nothing pending has no effect.
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("spurious_ready_valid", out_valid, 0);
    check("spurious_ready_tag", out_tag, m_results % TAG_MOD);

    // Gapped frame gives the same result as the gap-free one.
    do_frame(1'b0, 32'd16, 32'd64, 32'h20, 3, 0);

    // Reset mid-frame, then a sticky frame on reset-zero thresholds.
    send_word(32'h100, 1'b0);
    send_word(32'h200, 1'b0);
    pulse_reset();
    do_frame(1'b1, 32'd0, 32'd0, 32'h10, 0, 0);

    // Reset while a result is pending.
    send_word(32'd1, 1'b0);
    send_word(32'd200, 1'b0);
    send_word(32'd50, 1'b0);
    wait_valid(n);
    check("pre_abort_valid", out_valid, 1);
    pulse_reset();
    do_frame(1'b0, 32'd16, 32'd64, 32'h20, 0, 0);

    // Tag wrap and fire saturation over 257 firing frames from reset.
    pulse_reset();
    do_frame(1'b0, 32'd16, 32'd64, 32'h20, 0, 0);
    for (int i = 0; i < 256; i++)
      do_frame(1'b1, 32'd0, 32'd0, 32'($urandom_range(16, 63)), 0, 0);
    check("wrap_fire_sat", fire_cnt, FIRE_MAX);

    // Randomized frames against the model.
    pulse_reset();
    for (int i = 0; i < 60; i++)
      do_frame(1'($urandom_range(0, 2) == 0), 32'($urandom_range(0, 300)),
               32'($urandom_range(0, 300)), $urandom, $urandom_range(0, 2),
               $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nn_frame_driver.md
Name: nn_frame_driver

Overview:
- Sequential front/back-end for the combinational two-layer threshold network (8 synapses, power-of-two weights, window neuron).
- Accepts 32-bit frames over a valid/ready stream and holds the threshold and synapse inputs stable for the network.
- Waits a fixed settle time, samples the network's output axon and returns a tagged result over a second valid/ready stream.
- Also keeps frame and fire statistics.

Parameters:
- N1, 8, synapse vector width driven to layer 1 (1..32).
- SETTLE_CYCLES, 2, cycles the network inputs are held before the axon is sampled (>=1).
- TAG_W, 8, width of the frame tag counter.
- FIRE_W, 16, width of the saturating fire counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  32  frame word
- in_valid  in  1  in_data valid
- in_ready  out  1  driver can accept a word
- sticky_th  in  1  sampled on first word of a frame: 1 = reuse the held thresholds, frame is one word
- nn_s  out  N1  synapse vector to the network (registered)
- nn_th1  out  32  layer-1 neuron-1 threshold (registered)
- nn_th2  out  32  layer-1 neuron-2 threshold (registered)
- nn_ax  in  1  layer-2 axon from the network
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_ax  out  1  sampled axon
- out_tag  out  TAG_W  frame number of this result
- fire_cnt  out  FIRE_W  number of results with out_ax=1, saturating
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; nn_s, nn_th1, nn_th2, out_ax, out_tag, fire_cnt, settle counter all 0; out_valid=0; in_ready=1 on release.
- States: IDLE, GET_TH2, GET_S, SETTLE, RESULT. A word is accepted on an edge with in_valid&in_ready.
- in_ready=1 in IDLE, GET_TH2 and GET_S; 0 in SETTLE and RESULT.
- IDLE, accept with sticky_th=0: nn_th1<=in_data, go to GET_TH2.
- IDLE, accept with sticky_th=1: nn_s<=in_data[N1-1:0], thresholds unchanged, go to SETTLE.
- sticky_th is ignored outside IDLE. With sticky_th=1 before any full frame, the thresholds used are the reset zeros.
- GET_TH2, accept: nn_th2<=in_data, go to GET_S.
- GET_S, accept: nn_s<=in_data[N1-1:0], go to SETTLE. in_data[31:N1] is ignored.
- SETTLE: counter runs from 0 to SETTLE_CYCLES-1. On the edge where it equals SETTLE_CYCLES-1: out_ax<=nn_ax, out_valid<=1, fire_cnt increments if nn_ax=1 (saturates at all-ones), go to RESULT.
- Latency: if the last word is accepted at edge E, out_valid rises at edge E+SETTLE_CYCLES.
- RESULT: out_valid, out_ax and out_tag are held stable until out_ready=1. On that edge: out_valid<=0, out_tag<=out_tag+1 (wraps 2^TAG_W-1 to 0), go to IDLE.
- The first result carries out_tag=0.
- Stall: in_valid low in any GET state holds that state indefinitely, with no timeout. Partial frames persist.
- nn_s, nn_th1 and nn_th2 change only on accepted words. They remain held through SETTLE, RESULT and IDLE.
- out_ready while out_valid=0 has no effect. Words presented while in_ready=0 are not consumed.
- No same-cycle RESULT-to-accept overlap: the next word is accepted one cycle after the out handshake at the earliest, so throughput is at most one frame per SETTLE_CYCLES+2 cycles for sticky frames.
- Reset asserted mid-frame or mid-result aborts immediately. The result is lost, out_valid drops asynchronously and all registers return to reset values.

Decomposition:
- Shared package nn_pkg holds:
  - the state enum (IDLE, GET_TH2, GET_S, SETTLE, RESULT),
  - the frame word width constant (32),
  - default N1 and SETTLE_CYCLES constants used by the network top.
- One natural sub-module, nn_sat_counter: parameterised width, enable, saturating, async active-low reset. It is used for fire_cnt. Counters stay inline otherwise.

Test Plan:
- Full frame th1=16, th2=64, s=0x20 (sum 32), sticky_th=0, SETTLE_CYCLES=2 -> out_valid at E+2, out_ax=1, out_tag=0, fire_cnt=1.
- Sticky frame after the previous one, s=0x80 (sum 128 >= th2) -> out_ax=0, out_tag=1, fire_cnt unchanged, nn_th1/nn_th2 still 16/64.
- Back-pressure: hold out_ready=0 for 10 cycles in RESULT with in_valid=1 -> in_ready=0 throughout, out_ax/out_tag stable, no word consumed. Release -> next word accepted one cycle later.
- in_valid gaps of 3 cycles between frame words -> state holds in GET_TH2/GET_S, and the result matches the gap-free run.
- rst_n pulsed low during GET_S and during RESULT -> out_valid=0 immediately, all outputs 0, next frame tag=0.
- 256 firing frames with TAG_W=8 -> out_tag wraps to 0 on the 257th. fire_cnt with FIRE_W=4 saturates at 15.
